// File: rtl/nubus_pkg.sv
// nubus_pkg: shared definitions for the NuBus bus-acquisition scheduler.
//   - state_e      : scheduler FSM states
//   - NUBUS_ID_W   : width of the NuBus card ID / arbitration bus
//   - TMO_CLKS_DEF : default watchdog limit in ownership clocks
//   - rr_pick()    : round-robin winner selection over up to 8 requesters
package nubus_pkg;

  localparam int NUBUS_ID_W   = 4;
  localparam int TMO_CLKS_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Return the first set bit of req_v at or after rr_v, wrapping modulo n.
  // The scan runs downward so the smallest distance from rr_v wins.
  // If nothing is set, rr_v comes back unchanged (the caller gates on |req).
  function automatic logic [2:0] rr_pick(input logic [7:0]  req_v,
                                         input logic [2:0]  rr_v,
                                         input int unsigned n);
    logic [3:0] idx;
    logic [2:0] pick;
    pick = rr_v;
    for (int k = 7; k >= 0; k--) begin
      idx = {1'b0, rr_v} + 4'(k);
      if (idx >= 4'(n)) begin
        idx = idx - 4'(n);
      end
      if ((32'(k) < n) && req_v[idx[2:0]]) begin
        pick = idx[2:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/nubus_arb_contest.sv
// nubus_arb_contest: NuBus distributed ID contest for one card.
//   i/o summary:
//   nub_clkn  in  bus clock (rising edge)
//   nub_reset in  synchronous active-high reset
//   slot_id   in  card ID, active-high
//   nub_arbn  in  sampled /ARB lines (active low, wired-OR)
//   mst_arbcy in  master is arbitrating
//   arb_oe    out drive /ARB[i] low (combinational)
//   arb_grant out this card holds the winning ID (registered)
module nubus_arb_contest
  import nubus_pkg::*;
(
  input  logic                  nub_clkn,
  input  logic                  nub_reset,
  input  logic [NUBUS_ID_W-1:0] slot_id,
  input  logic [NUBUS_ID_W-1:0] nub_arbn,
  input  logic                  mst_arbcy,
  output logic [NUBUS_ID_W-1:0] arb_oe,
  output logic                  arb_grant
);

  logic [NUBUS_ID_W-1:0] w_arb;
  logic [NUBUS_ID_W-1:0] w_lose;

  assign w_arb  = ~nub_arbn;
  // A higher bit that someone else drives while our ID has it clear means
  // we have lost that position; all lower bits must then be released.
  assign w_lose = w_arb & ~slot_id;

  // ID contest drivers: each bit backs off once a more significant bit is lost.
  always_comb begin
    arb_oe[3] = mst_arbcy & slot_id[3];
    arb_oe[2] = mst_arbcy & slot_id[2] & ~w_lose[3];
    arb_oe[1] = mst_arbcy & slot_id[1] & ~(|w_lose[3:2]);
    arb_oe[0] = mst_arbcy & slot_id[0] & ~(|w_lose[3:1]);
  end

  // Grant flop: the bus has settled to exactly our ID during arbitration.
  always_ff @(posedge nub_clkn) begin
    if (nub_reset) begin
      arb_grant <= 1'b0;
    end else begin
      arb_grant <= mst_arbcy & (w_arb == slot_id);
    end
  end

endmodule

// File: rtl/nubus_master_sched.sv
// nubus_master_sched: round-robin sharing of the NuBus master controller
// among N_REQ local requesters, with transaction tracking and watchdog.
//   i/o summary:
//   nub_clkn, nub_reset      clock / synchronous active-high reset
//   slot_id                  card ID (active-high)
//   req, req_lock            per-requester level request and lock flag
//   gnt, done                one-hot served requester / end-of-transaction pulse
//   tmo_err                  one-clock watchdog pulse
//   cpu_valid, cpu_lock      start / lock controls to the master
//   mst_arbcy, mst_owner     master status
//   arb_grant, nub_arbn,
//   rqst_oe, arb_oe          NuBus contest signals
module nubus_master_sched
  import nubus_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int TMO_CLKS = TMO_CLKS_DEF
) (
  input  logic                  nub_clkn,
  input  logic                  nub_reset,
  input  logic [NUBUS_ID_W-1:0] slot_id,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      req_lock,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      done,
  output logic                  tmo_err,
  output logic                  cpu_valid,
  output logic                  cpu_lock,
  input  logic                  mst_arbcy,
  input  logic                  mst_owner,
  output logic                  arb_grant,
  input  logic [NUBUS_ID_W-1:0] nub_arbn,
  output logic                  rqst_oe,
  output logic [NUBUS_ID_W-1:0] arb_oe
);

  localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W  = $clog2(TMO_CLKS + 1);

  state_e           r_state;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_rr;
  logic             r_lock;
  logic [WD_W-1:0]  r_wdog;
  logic             r_tmo;

  logic [7:0]       w_req8;
  logic [2:0]       w_rr3;
  logic [SEL_W-1:0] w_pick;
  logic [N_REQ-1:0] w_sel_1h;

  // Widen request vector and pointer to the fixed width of the pick helper.
  always_comb begin
    w_req8             = 8'h00;
    w_req8[N_REQ-1:0]  = req;
    w_rr3              = 3'd0;
    w_rr3[SEL_W-1:0]   = r_rr;
  end

  assign w_pick   = SEL_W'(rr_pick(w_req8, w_rr3, N_REQ));
  assign w_sel_1h = N_REQ'(1) << r_sel;
  assign tmo_err  = r_tmo;
  assign rqst_oe  = mst_arbcy & ~mst_owner;

  // Scheduler FSM, round-robin pointer and ownership watchdog.
  always_ff @(posedge nub_clkn) begin
    if (nub_reset) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_rr    <= '0;
      r_lock  <= 1'b0;
      r_wdog  <= '0;
      r_tmo   <= 1'b0;
    end else begin
      r_tmo <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_sel   <= w_pick;
            r_lock  <= req_lock[w_pick];
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          r_wdog <= '0;
          if (mst_owner) begin
            r_state <= ST_XFER;
          end
        end
        ST_XFER: begin
          // Counter saturates at the limit so the pulse cannot repeat.
          if (r_wdog != WD_W'(TMO_CLKS)) begin
            r_wdog <= r_wdog + WD_W'(1);
          end
          if (r_wdog == WD_W'(TMO_CLKS - 1)) begin
            r_tmo <= 1'b1;
          end
          if (!mst_owner) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_rr    <= (r_sel == SEL_W'(N_REQ - 1)) ? '0 : r_sel + SEL_W'(1);
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    gnt       = '0;
    done      = '0;
    cpu_valid = 1'b0;
    cpu_lock  = 1'b0;
    case (r_state)
      ST_REQ: begin
        gnt       = w_sel_1h;
        cpu_valid = 1'b1;
        cpu_lock  = r_lock;
      end
      ST_XFER: begin
        gnt      = w_sel_1h;
        cpu_lock = r_lock;
      end
      ST_DONE: begin
        done = w_sel_1h;
      end
      default: begin
        gnt = '0;
      end
    endcase
  end

  nubus_arb_contest u_contest (
    .nub_clkn  (nub_clkn),
    .nub_reset (nub_reset),
    .slot_id   (slot_id),
    .nub_arbn  (nub_arbn),
    .mst_arbcy (mst_arbcy),
    .arb_oe    (arb_oe),
    .arb_grant (arb_grant)
  );

endmodule

// File: tb/tb_nubus_master_sched.sv
// tb_nubus_master_sched: randomized self-checking bench with a
// transaction-level reference model of the scheduler and a bit-serial
// model of the NuBus ID contest.
module tb_nubus_master_sched;

  localparam int N   = 2;
  localparam int TMO = 8;

  logic         nub_clkn = 1'b0;
  logic         nub_reset;
  logic [3:0]   slot_id;
  logic [N-1:0] req, req_lock, gnt, done;
  logic         tmo_err, cpu_valid, cpu_lock;
  logic         mst_arbcy, mst_owner, arb_grant, rqst_oe;
  logic [3:0]   nub_arbn, arb_oe;

  int n_checks = 0;
  int n_fail   = 0;
  int m_rr     = 0;

  nubus_master_sched #(.N_REQ(N), .TMO_CLKS(TMO)) dut (
    .nub_clkn  (nub_clkn),
    .nub_reset (nub_reset),
    .slot_id   (slot_id),
    .req       (req),
    .req_lock  (req_lock),
    .gnt       (gnt),
    .done      (done),
    .tmo_err   (tmo_err),
    .cpu_valid (cpu_valid),
    .cpu_lock  (cpu_lock),
    .mst_arbcy (mst_arbcy),
    .mst_owner (mst_owner),
    .arb_grant (arb_grant),
    .nub_arbn  (nub_arbn),
    .rqst_oe   (rqst_oe),
    .arb_oe    (arb_oe)
  );

  always #5 nub_clkn = ~nub_clkn;

  initial begin
    #300000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Contest model: walk from MSB; once the bus shows a 1 where our ID has 0,
  // every lower position is given up.
  function automatic logic [3:0] m_oe(input logic [3:0] s, input logic [3:0] a);
    logic lost;
    lost = 1'b0;
    m_oe = 4'h0;
    for (int i = 3; i >= 0; i--) begin
      m_oe[i] = s[i] & ~lost;
      if (a[i] && !s[i]) lost = 1'b1;
    end
  endfunction

  function automatic int m_pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  // One clock; grant expectation is formed from the inputs the edge samples.
  task automatic tick();
    logic eg;
    eg = !nub_reset && mst_arbcy && ((~nub_arbn) == slot_id);
    @(posedge nub_clkn);
    #1;
    chk("arb_grant", {31'd0, arb_grant}, {31'd0, eg});
  endtask

  // Drive the settled /ARB state given competitor IDs, check contest outputs.
  task automatic set_bus(input logic cy, input logic [3:0] comp);
    logic [3:0] a;
    logic [3:0] eo;
    a = comp;
    for (int it = 0; it < 3; it++) a = comp | (cy ? m_oe(slot_id, a) : 4'h0);
    mst_arbcy = cy;
    nub_arbn  = ~a;
    #1;
    eo = cy ? m_oe(slot_id, ~nub_arbn) : 4'h0;
    chk("arb_oe", {28'd0, arb_oe}, {28'd0, eo});
    chk("rqst_oe", {31'd0, rqst_oe}, {31'd0, cy & ~mst_owner});
  endtask

  task automatic run_txn(input logic [N-1:0] r, input logic [N-1:0] l, input int d,
                         input int len, input logic [N-1:0] r_after);
    int sel;
    logic [N-1:0] oh;
    sel = m_pick(r);
    oh  = N'(1) << sel;
    req = r;
    req_lock = l;
    tick();
    chk("cpu_valid_req", {31'd0, cpu_valid}, 32'd1);
    chk("gnt_req", {30'd0, gnt}, {30'd0, oh});
    chk("cpu_lock_req", {31'd0, cpu_lock}, {31'd0, l[sel]});
    req = r_after;
    req_lock = N'($urandom);
    for (int i = 0; i < d; i++) begin
      set_bus(1'($urandom_range(0, 1)), 4'($urandom));
      tick();
      chk("cpu_valid_wait", {31'd0, cpu_valid}, 32'd1);
      chk("gnt_wait", {30'd0, gnt}, {30'd0, oh});
    end
    set_bus(1'b0, 4'h0);
    mst_owner = 1'b1;
    tick();
    chk("cpu_valid_xfer", {31'd0, cpu_valid}, 32'd0);
    chk("gnt_xfer", {30'd0, gnt}, {30'd0, oh});
    for (int c = 1; c <= len; c++) begin
      if (c == len) mst_owner = 1'b0;
      tick();
      chk("tmo_err", {31'd0, tmo_err}, {31'd0, (c == TMO)});
      if (c < len) begin
        chk("done_early", {30'd0, done}, 32'd0);
        chk("gnt_hold", {30'd0, gnt}, {30'd0, oh});
      end else begin
        chk("done_pulse", {30'd0, done}, {30'd0, oh});
      end
    end
    m_rr = (sel + 1) % N;
    tick();
    chk("done_clear", {30'd0, done}, 32'd0);
    chk("gnt_idle", {30'd0, gnt}, 32'd0);
    chk("cpu_valid_idle", {31'd0, cpu_valid}, 32'd0);
    chk("tmo_idle", {31'd0, tmo_err}, 32'd0);
    req = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, {30'd0, gnt}, 32'd0);
    chk({tag, "_done"}, {30'd0, done}, 32'd0);
    chk({tag, "_valid"}, {31'd0, cpu_valid}, 32'd0);
    chk({tag, "_lock"}, {31'd0, cpu_lock}, 32'd0);
    chk({tag, "_tmo"}, {31'd0, tmo_err}, 32'd0);
  endtask

  initial begin
    nub_reset = 1'b1; slot_id = 4'hE; req = '0; req_lock = '0;
    mst_arbcy = 1'b0; mst_owner = 1'b0; nub_arbn = 4'hF;
    tick(); tick();
    chk_all_zero("reset");
    nub_reset = 1'b0;
    tick();
    chk_all_zero("post_reset");

    // Contest loss against ID C, then win once the competitor releases.
    slot_id = 4'h9;
    set_bus(1'b1, 4'hC);
    tick();
    chk("loss_oe", {28'd0, arb_oe}, 32'h8);
    set_bus(1'b1, 4'h0);
    tick();
    chk("win_oe", {28'd0, arb_oe}, 32'h9);
    set_bus(1'b0, 4'h0);
    tick();
    // Uncontested with ID E.
    slot_id = 4'hE;
    set_bus(1'b1, 4'h0);
    tick();
    chk("solo_oe", {28'd0, arb_oe}, 32'hE);
    set_bus(1'b0, 4'h0);
    tick();
    for (int i = 0; i < 20; i++) begin
      slot_id = 4'($urandom);
      set_bus(1'($urandom_range(0, 1)), 4'($urandom));
      tick();
    end
    set_bus(1'b0, 4'h0);
    slot_id = 4'hE;

    // Round-robin from pointer 0 with both requesters held.
    for (int i = 0; i < 4; i++) run_txn(2'b11, 2'b00, 1, 3, 2'b11);
    // Single requester, arbitration during the wait.
    run_txn(2'b01, 2'b00, 2, 4, 2'b00);
    // Locked access from requester 1.
    run_txn(2'b10, 2'b10, 2, 3, 2'b10);
    // Watchdog: long ownership, and the exact-limit boundary.
    run_txn(2'b01, 2'b00, 0, 20, 2'b00);
    run_txn(2'b10, 2'b00, 0, TMO, 2'b00);

    // Reset in XFER after pointer moved to 1.
    run_txn(2'b01, 2'b00, 0, 2, 2'b00);
    req = 2'b10; tick();
    chk("rst_sel", {30'd0, gnt}, 32'h2);
    req = '0; mst_owner = 1'b1; tick(); tick();
    nub_reset = 1'b1; tick();
    chk_all_zero("mid_rst");
    nub_reset = 1'b0; mst_owner = 1'b0;
    tick();
    chk_all_zero("after_rst");
    m_rr = 0;
    run_txn(2'b11, 2'b01, 0, 2, 2'b00);

    // Randomized transactions.
    for (int i = 0; i < 30; i++) begin
      run_txn(N'($urandom_range(1, 3)), N'($urandom), $urandom_range(0, 3),
              $urandom_range(1, 12), N'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
